// File: rtl/strobe_serial_tx_if.sv
// Purpose: word handshake bundle between a producer and strobe_serial_tx.
// Latency: none; carries wires only.
// Backpressure: producer holds in_valid/in_data until it sees in_ready on an edge.
interface strobe_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/strobe_serial_tx.sv
// Purpose: parallel-to-serial transmitter with a generated strobe and guaranteed setup/hold around each strobe rise.
// Latency: WIDTH*(SETUP+HIGH+HOLD)+1 cycles from the accept edge back to IDLE, then one more IDLE cycle before the next accept.
// Backpressure: in_ready is high only in IDLE; inputs are ignored while busy.
module strobe_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int SETUP     = 2,
  parameter int HIGH      = 2,
  parameter int HOLD      = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     MasterClock,
  input  logic                     reset,
  strobe_serial_tx_if.slave        in_bus,
  output logic                     ser_d,
  output logic                     ser_clk,
  output logic                     ser_frame,
  output logic                     busy
);

  // The phase counter must span the longest of the three phases.
  localparam int MAX_PH = (SETUP > HIGH) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                         : ((HIGH > HOLD) ? HIGH : HOLD);
  localparam int PW = (MAX_PH < 2) ? 1 : $clog2(MAX_PH + 1);
  localparam int BW = $clog2(WIDTH + 1);

  // Zero-length phases or an out-of-range word width cannot produce a valid waveform.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("strobe_serial_tx: WIDTH must be in 1..32");
  end
  if (SETUP < 1 || HIGH < 1 || HOLD < 1) begin : g_bad_phase
    $error("strobe_serial_tx: SETUP, HIGH and HOLD must each be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_FRAME
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_nxt;
  logic [BW-1:0]    bit_q;
  logic [PW-1:0]    ph_q;

  // The bit presented on the line is always at the head end of the shift register.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign shift_nxt = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  // Single registered FSM: every output is a flop, so the latch side never sees input-driven glitches.
  always_ff @(posedge MasterClock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      shift_q         <= '0;
      bit_q           <= '0;
      ph_q            <= '0;
      in_bus.in_ready <= 1'b1;
      ser_d           <= 1'b0;
      ser_clk         <= 1'b0;
      ser_frame       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ser_frame <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_bus.in_valid) begin
            shift_q         <= in_bus.in_data;
            ser_d           <= lead_bit(in_bus.in_data);
            bit_q           <= '0;
            ph_q            <= '0;
            in_bus.in_ready <= 1'b0;
            busy            <= 1'b1;
            state_q         <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (ph_q == PW'(SETUP - 1)) begin
            ph_q    <= '0;
            ser_clk <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_HIGH: begin
          if (ph_q == PW'(HIGH - 1)) begin
            ph_q    <= '0;
            ser_clk <= 1'b0;
            state_q <= S_HOLD;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_HOLD: begin
          if (ph_q == PW'(HOLD - 1)) begin
            ph_q <= '0;
            if (bit_q == BW'(WIDTH - 1)) begin
              ser_frame <= 1'b1;
              state_q   <= S_FRAME;
            end else begin
              shift_q <= shift_nxt;
              ser_d   <= lead_bit(shift_nxt);
              bit_q   <= bit_q + BW'(1);
              state_q <= S_SETUP;
            end
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end
        S_FRAME: begin
          ser_d           <= 1'b0;
          in_bus.in_ready <= 1'b1;
          busy            <= 1'b0;
          state_q         <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
